// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffer.
// Holds the default payload width, the all-zero word and NOP register
// address constants, the bit offsets of each field inside a packed stage
// payload, and a helper that validates buffer depths.
package pipe_pkg;

   localparam int PAYLOAD_W_DEF = 112;

   localparam logic [31:0] ZeroWord   = 32'h0000_0000;
   localparam logic [4:0]  NOPRegAddr = 5'b00000;

   // Packed payload layout, LSB first. The top bit is reserved so the
   // total matches PAYLOAD_W_DEF.
   localparam int WD_OFF         = 0;    // 5 bits, destination register
   localparam int WREG_OFF       = 5;    // 1 bit, register write enable
   localparam int WDATA_OFF      = 6;    // 32 bits, register write data
   localparam int HI_OFF         = 38;   // 32 bits
   localparam int LO_OFF         = 70;   // 32 bits
   localparam int WHILO_OFF      = 102;  // 1 bit, hi/lo write enable
   localparam int LLBIT_WE_OFF   = 103;  // 1 bit
   localparam int LLBIT_VAL_OFF  = 104;  // 1 bit
   localparam int CP0_WE_OFF     = 105;  // 1 bit
   localparam int CP0_WADDR_OFF  = 106;  // 5 bits
   localparam int RESERVED_OFF   = 111;  // 1 bit

   // Only power-of-two depths up to 8 keep the pointer wrap trivial.
   function automatic bit depth_is_legal(input int d);
      return (d == 1) || (d == 2) || (d == 4) || (d == 8);
   endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// Storage array for pipe_stage_buf.
// DEPTH entries of PAYLOAD_W bits, one synchronous write port and one
// asynchronous read port. Contents are never cleared; the owner masks the
// read data when nothing valid is held.
// Ports:
//   clk      clock
//   we       write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  read data (combinational from rd_addr)
module pipe_stage_mem
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W = PAYLOAD_W_DEF,
   parameter int DEPTH     = 2,
   parameter int ADDR_W    = 1
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [PAYLOAD_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic [PAYLOAD_W-1:0] rd_data
);

   logic [PAYLOAD_W-1:0] mem_reg [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage buffer: a small FIFO between two pipeline stages.
// Empty buffer presents an all-zero payload so every downstream write
// enable reads as disabled (a bubble).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         drop all held and incoming entries
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and head payload
//   count         number of entries held
//   stall_cycles  saturating count of cycles the head was held back
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W = PAYLOAD_W_DEF,
   parameter int DEPTH     = 2,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [PAYLOAD_W-1:0]         in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PAYLOAD_W-1:0]         out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [CNT_W-1:0]             stall_cycles
);

   localparam int CNT_BITS = $clog2(DEPTH + 1);
   // DEPTH=1 still gets a 1-bit pointer that simply never moves.
   localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_BITS-1:0] DEPTH_C   = CNT_BITS'(DEPTH);
   localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]    STALL_MAX = '1;

   generate
      if (!depth_is_legal(DEPTH)) begin : g_bad_depth
         $error("pipe_stage_buf: DEPTH must be 1, 2, 4 or 8");
      end
   endgenerate

   logic [CNT_BITS-1:0]  count_reg, count_next;
   logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]     stall_reg, stall_next;
   logic [PAYLOAD_W-1:0] rd_data;
   logic                 push;
   logic                 pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Handshake readiness depends on registered state only, so there is no
   // combinational path from out_ready back to in_ready.
   assign in_ready  = (count_reg < DEPTH_C);
   assign out_valid = (count_reg != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_comb begin
      count_next  = count_reg;
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      stall_next  = stall_reg;

      if (flush) begin
         count_next  = '0;
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end else begin
         if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
         end
         if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
         end
         case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
         endcase
      end

      // Counts held-back cycles; flush cycles are not stalls and do not clear it.
      if (out_valid && !out_ready && !flush && (stall_reg != STALL_MAX)) begin
         stall_next = stall_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         stall_reg  <= '0;
      end else begin
         count_reg  <= count_next;
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         stall_reg  <= stall_next;
      end
   end

   pipe_stage_mem #(
      .PAYLOAD_W (PAYLOAD_W),
      .DEPTH     (DEPTH),
      .ADDR_W    (PTR_W)
   ) u_mem (
      .clk     (clk),
      .we      (push && !rst),
      .wr_addr (wr_ptr_reg),
      .wr_data (in_data),
      .rd_addr (rd_ptr_reg),
      .rd_data (rd_data)
   );

   // Stale array contents never leak out: an empty buffer shows a bubble.
   assign out_data     = out_valid ? rd_data : '0;
   assign count        = count_reg;
   assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf (DEPTH=2). A second instance with
// a 4-bit stall counter shares the inputs to exercise counter saturation.
module tb_pipe_stage_buf;

   localparam int PW    = 112;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [PW-1:0] in_data = '0;

   logic          in_ready, out_valid;
   logic [PW-1:0] out_data;
   logic [1:0]    count;
   logic [15:0]   stall_cycles;

   logic          in_ready4, out_valid4;
   logic [PW-1:0] out_data4;
   logic [1:0]    count4;
   logic [3:0]    stall_cycles4;

   int checks = 0;
   int errors = 0;

   logic [PW-1:0] exp_q[$];
   int            exp_stall  = 0;
   int            exp_stall4 = 0;
   bit            model_ok   = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.PAYLOAD_W(PW), .DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .stall_cycles(stall_cycles)
   );

   pipe_stage_buf #(.PAYLOAD_W(PW), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
      .count(count4), .stall_cycles(stall_cycles4)
   );

   // One clock: check outputs against the scoreboard before the edge,
   // update the scoreboard at the edge, check the stall counters after it.
   task automatic step();
      int            sz;
      logic [PW-1:0] head;
      bit            acc, popx;
      #1;
      sz   = exp_q.size();
      head = (sz > 0) ? exp_q[0] : '0;
      if (model_ok) begin
         checks++;
         if (out_data !== head) begin
            errors++;
            $display("FAIL sb_out_data act=%h exp=%h", out_data, head);
         end
         checks++;
         if (out_valid !== (sz != 0)) begin
            errors++;
            $display("FAIL sb_out_valid act=%b exp=%b", out_valid, (sz != 0));
         end
         checks++;
         if (count !== 2'(sz)) begin
            errors++;
            $display("FAIL sb_count act=%0d exp=%0d", count, sz);
         end
         checks++;
         if (in_ready !== (sz < DEPTH)) begin
            errors++;
            $display("FAIL sb_in_ready act=%b exp=%b", in_ready, (sz < DEPTH));
         end
      end
      acc  = in_valid && (sz < DEPTH) && !flush && !rst;
      popx = (sz > 0) && out_ready && !flush && !rst;
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         exp_stall  = 0;
         exp_stall4 = 0;
         model_ok   = 1'b1;
      end else begin
         if (!flush && sz > 0 && !out_ready) begin
            if (exp_stall < 65535) exp_stall++;
            if (exp_stall4 < 15) exp_stall4++;
         end
         if (flush) begin
            exp_q.delete();
            $display("flush");
         end else begin
            if (popx) begin
               void'(exp_q.pop_front());
               $display("pop  data=%0h", head);
            end
            if (acc) begin
               exp_q.push_back(in_data);
               $display("push data=%0h", in_data);
            end
         end
      end
      #1;
      if (model_ok) begin
         checks++;
         if (stall_cycles !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL sb_stall act=%0d exp=%0d", stall_cycles, exp_stall);
         end
         checks++;
         if (stall_cycles4 !== 4'(exp_stall4)) begin
            errors++;
            $display("FAIL sb_stall4 act=%0d exp=%0d", stall_cycles4, exp_stall4);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      checks++;
      if (count !== 2'd0) begin errors++; $display("FAIL reset_count act=%0d exp=0", count); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready act=%b exp=1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid act=%b exp=0", out_valid); end
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL reset_out_data act=%h exp=0", out_data); end
      checks++;
      if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall act=%0d exp=0", stall_cycles); end
   endtask

   task automatic test_fill_stall();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = PW'(32'hA);
      step();
      in_data = PW'(32'hB);
      step();
      in_valid = 1'b0;
      checks++;
      if (count !== 2'd2) begin errors++; $display("FAIL fill_count act=%0d exp=2", count); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready act=%b exp=0", in_ready); end
      checks++;
      if (stall_cycles !== 16'd1) begin errors++; $display("FAIL fill_stall1 act=%0d exp=1", stall_cycles); end
      repeat (3) step();
      checks++;
      if (out_data !== PW'(32'hA)) begin errors++; $display("FAIL fill_hold act=%h exp=a", out_data); end
      checks++;
      if (stall_cycles !== 16'd4) begin errors++; $display("FAIL fill_stall4 act=%0d exp=4", stall_cycles); end
   endtask

   task automatic test_full_ignore();
      in_valid = 1'b1; in_data = PW'(32'hC); out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (count !== 2'd1) begin errors++; $display("FAIL full_count act=%0d exp=1", count); end
      checks++;
      if (out_data !== PW'(32'hB)) begin errors++; $display("FAIL full_head act=%h exp=b", out_data); end
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drain act=%b exp=0", out_valid); end
   endtask

   task automatic test_push_pop();
      out_ready = 1'b0; in_valid = 1'b1; in_data = PW'(32'h5);
      step();
      in_data = PW'(32'h6); out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (count !== 2'd1) begin errors++; $display("FAIL pp_count act=%0d exp=1", count); end
      checks++;
      if (out_data !== PW'(32'h6)) begin errors++; $display("FAIL pp_head act=%h exp=6", out_data); end
      step();
   endtask

   task automatic test_flush();
      int stall_before;
      out_ready = 1'b0; in_valid = 1'b1; in_data = PW'(32'h11);
      step();
      in_data = PW'(32'h12);
      step();
      stall_before = exp_stall;
      flush = 1'b1; in_data = PW'(32'h13);
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (count !== 2'd0) begin errors++; $display("FAIL flush_count act=%0d exp=0", count); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid act=%b exp=0", out_valid); end
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL flush_data act=%h exp=0", out_data); end
      checks++;
      if (stall_cycles !== 16'(stall_before)) begin
         errors++; $display("FAIL flush_stall act=%0d exp=%0d", stall_cycles, stall_before);
      end
   endtask

   task automatic test_saturate();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      step();
      rst = 1'b0;
      in_valid = 1'b1; in_data = PW'(32'h77);
      step();
      in_valid = 1'b0;
      repeat (20) step();
      checks++;
      if (stall_cycles4 !== 4'd15) begin errors++; $display("FAIL sat_stall4 act=%0d exp=15", stall_cycles4); end
      checks++;
      if (stall_cycles !== 16'd20) begin errors++; $display("FAIL sat_stall16 act=%0d exp=20", stall_cycles); end
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1; in_data = PW'(32'h21);
      step();
      in_data = PW'(32'h22);
      step();
      rst = 1'b1; flush = 1'b1; in_data = PW'(32'h23);
      step();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (count !== 2'd0) begin errors++; $display("FAIL rmid_count act=%0d exp=0", count); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready act=%b exp=1", in_ready); end
      checks++;
      if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rmid_stall act=%0d exp=0", stall_cycles); end
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL rmid_data act=%h exp=0", out_data); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] r;
      for (int i = 0; i < 300; i++) begin
         r = {$urandom(), $urandom(), $urandom(), $urandom()};
         in_data   = r[PW-1:0];
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         step();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      checks++;
      if (count !== 2'd0) begin errors++; $display("FAIL b2b_drain act=%0d exp=0", count); end
   endtask

   initial begin
      test_reset();
      test_fill_stall();
      test_full_ignore();
      test_push_pop();
      test_flush();
      test_saturate();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 112, width in bits of one stage payload (wd, wreg, wdata, hi, lo, whilo, LLbit, CP0 fields, packed).
REQ-002 SHALL have parameter DEPTH, default 2, entry count; legal values 1, 2, 4, 8; DEPTH=1 is a plain stage register.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-004 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  in  1  discard all held and incoming entries.
REQ-007 SHALL have port in_valid  in  1  upstream payload present.
REQ-008 SHALL have port in_ready  out  1  buffer accepts a payload this cycle.
REQ-009 SHALL have port in_data  in  PAYLOAD_W  upstream payload.
REQ-010 SHALL have port out_valid  out  1  head entry present.
REQ-011 SHALL have port out_ready  in  1  downstream consumes the head this cycle.
REQ-012 SHALL have port out_data  out  PAYLOAD_W  head payload, all-zero when empty (bubble).
REQ-013 SHALL have port count  out  clog2(DEPTH+1)  entries held.
REQ-014 SHALL have port stall_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Push SHALL occur when in_valid=1 and in_ready=1 and flush=0; pop SHALL occur when out_valid=1 and out_ready=1 and flush=0.
REQ-016 in_ready SHALL equal (count < DEPTH), registered-state only, with no combinational path from out_ready.
REQ-017 Latency SHALL be one cycle: a payload pushed at edge N appears on out_data with out_valid=1 after edge N when the buffer was empty.
REQ-018 Ordering SHALL be strict FIFO; read and write pointers SHALL wrap modulo DEPTH.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged and SHALL present the next-oldest entry, or the new entry if count was 1.
REQ-020 When full, in_valid=1 SHALL be ignored with no state change, even if out_ready=1 in that cycle.
REQ-021 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 out_valid SHALL equal (count != 0); out_data SHALL be zero whenever count=0, so every write-enable field downstream reads disabled.
REQ-023 flush=1 SHALL set count=0, reset both pointers and drop any same-cycle push and pop; flush SHALL take priority over all other events.
REQ-024 stall_cycles SHALL increment by 1 for each cycle with out_valid=1, out_ready=0 and flush=0, and SHALL saturate at 2^CNT_W-1.
REQ-025 stall_cycles SHALL NOT be cleared by flush.

Reset
REQ-026 rst=1 SHALL, at the next edge, set count=0, pointers=0, stall_cycles=0, out_valid=0, out_data=0 and in_ready=1, overriding flush and all handshakes.
REQ-027 Reset asserted mid-transfer SHALL discard all held entries with no partial output.
REQ-028 Storage array contents need not be cleared; out_data masking SHALL guarantee zero output.

Structure
REQ-029 Package pipe_pkg SHALL hold the PAYLOAD_W default, the ZeroWord and NOPRegAddr constants, and the stage payload field offsets.
REQ-030 Storage SHALL be the sub-module pipe_stage_mem (DEPTH x PAYLOAD_W, one write port, one asynchronous read port); pointer, count and counter logic stay in pipe_stage_buf.
REQ-031 DEPTH outside {1,2,4,8} SHALL be rejected at elaboration.

Verification
REQ-032 DEPTH=2: push 0xA then 0xB on consecutive cycles, out_ready=0 -> count=2, in_ready=0, out_data=0xA held, stall_cycles=1 after the first stalled cycle, then increments each cycle.
REQ-033 DEPTH=2 full, in_valid=1 with 0xC, out_ready=1 -> 0xA popped, 0xC not accepted, count=1, out_data=0xB.
REQ-034 count=1 with head 0x5, push 0x6 and pop same cycle -> count=1, out_data=0x6 next cycle.
REQ-035 count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, out_data=0, stall_cycles unchanged.
REQ-036 CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cycles=15.
REQ-037 rst=1 while count=2 and flush=1 -> next cycle count=0, in_ready=1, stall_cycles=0, out_data=0.
